cntr_seq: RTL and testbench
===========================

Name: cntr_seq

Overview:
- Upstream sequencer for the team's loadable up-counter (inputs cnt_in/load/enab, output cnt_out).
- On a start request it drives `load` with a programmed start value, then asserts `enab` until the counter's fed-back value reaches a programmed limit, and flags completion.
- Supports one-shot and auto-reload (periodic) modes, abort, and a saturating count of completed periods.
- The counter's cnt_out connects back to this block's `cnt_val` input.

Parameters:
- WIDTH, 5, width of the counter datapath (start value, limit, cnt_val, cnt_in).
- PCNT_W, 8, width of the completed-period counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  request to begin a sequence; sampled only in IDLE.
- abort  in  1  cancels an active sequence.
- auto_reload  in  1  mode select; 1 = periodic, 0 = one-shot; sampled with start.
- start_val  in  WIDTH  value loaded into the counter; sampled with start.
- limit  in  WIDTH  terminal value; sampled with start.
- cnt_val  in  WIDTH  counter feedback (the counter's cnt_out).
- cnt_in  out  WIDTH  load value to the counter; equals captured start_val.
- load  out  1  counter load strobe.
- enab  out  1  counter enable.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse per completed period.
- pcnt  out  PCNT_W  completed periods since last start; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, captured regs=0, done=0, pcnt=0. Therefore cnt_in=0, load=0, enab=0, busy=0 while in reset.
- States: IDLE, LOAD, RUN.
- IDLE:
  - On start=1 and abort=0: capture start_val, limit and auto_reload; clear pcnt to 0; go to LOAD.
  - start together with abort is ignored.
- LOAD (one cycle):
  - load=1 (combinational from state); cnt_in = captured start_val.
  - Next state is RUN; abort=1 goes to IDLE instead.
- RUN:
  - enab = (cnt_val != captured limit); combinational, so the counter never overshoots the limit.
  - When cnt_val == limit: enab=0; register done=1 for the next cycle; pcnt increments (saturating).
  - After the match, next state is LOAD if auto_reload is captured as 1, otherwise IDLE.
- Latency: start in cycle 0 -> load in cycle 1 -> cnt_val=start_val in cycle 2.
  - enab is high for exactly ((limit - start_val) mod 2^WIDTH) cycles.
  - done is high in the cycle after the match.
- start_val == limit: match in the first RUN cycle; enab is never asserted; done in the following cycle.
- limit < start_val: the counter wraps modulo 2^WIDTH through all-ones to 0 and on to limit. This is legal and not an error.
- Auto-reload period: LOAD, then RUN with N enab cycles, then one match cycle. Period = N+2 cycles; done pulses once per period.
- abort in LOAD or RUN:
  - Next state is IDLE; no done for the interrupted period; pcnt holds.
  - If abort coincides with a match cycle, abort wins: no done and no pcnt increment.
- start while busy: ignored; captured values and mode are unchanged.
- Changes to start_val, limit or auto_reload after capture have no effect until the next accepted start.
- Counter contract: this block owns the counter's load/enab. The counter's own reset must be held for at least as long as rst_n.

Test Plan:
- One-shot: WIDTH=5, start_val=3, limit=7, start pulse in cycle 0 -> load=1 only in cycle 1; enab high cycles 2-5 (cnt_val 3,4,5,6); cnt_val=7 in cycle 6 with enab=0; done=1 and busy=0 in cycle 7; pcnt=1.
- Wrap: start_val=30, limit=2 -> exactly 4 enab cycles (30,31,0,1), counter stops at 2, one done pulse.
- Equal values: start_val=limit=9 -> load cycle, enab never asserted, done two cycles after load; pcnt=1.
- Auto-reload: start_val=0, limit=3 -> done every 5 cycles; pcnt reads 1,2,3 after three periods; abort mid-RUN -> IDLE next cycle, no further done, pcnt held at 3.
- Collisions: abort in the match cycle -> no done, pcnt unchanged. start during RUN -> ignored, period length unchanged. start+abort in IDLE -> remains IDLE.
- Reset: drop rst_n mid-RUN asynchronously -> load, enab, busy, done and pcnt go to 0 without waiting for a clk edge; release -> IDLE until the next start.

Source files
------------

// File: rtl/cntr_seq_if.sv
// ---------------------------------------------------------------------------
// cntr_seq_if
// Bundles the request/status side and the counter side of the cntr_seq
// sequencer into one interface.
//
//   Request side : start, abort, auto_reload, start_val, limit   (to seq)
//                  busy, done, pcnt                              (from seq)
//   Counter side : cnt_val (counter cnt_out fed back)            (to seq)
//                  cnt_in, load, enab                            (from seq)
//
//   slave  modport : the sequencer itself
//   master modport : whatever drives requests and hosts the counter
// ---------------------------------------------------------------------------
interface cntr_seq_if #(
    parameter int WIDTH  = 5,
    parameter int PCNT_W = 8
);
    logic              start;
    logic              abort;
    logic              auto_reload;
    logic [WIDTH-1:0]  start_val;
    logic [WIDTH-1:0]  limit;
    logic [WIDTH-1:0]  cnt_val;
    logic [WIDTH-1:0]  cnt_in;
    logic              load;
    logic              enab;
    logic              busy;
    logic              done;
    logic [PCNT_W-1:0] pcnt;

    modport slave (
        input  start, abort, auto_reload, start_val, limit, cnt_val,
        output cnt_in, load, enab, busy, done, pcnt
    );

    modport master (
        output start, abort, auto_reload, start_val, limit, cnt_val,
        input  cnt_in, load, enab, busy, done, pcnt
    );
endinterface

// File: rtl/cntr_seq.sv
// ---------------------------------------------------------------------------
// cntr_seq
// Upstream sequencer for a loadable up-counter. A start request loads the
// counter with a captured start value, then enables it until its fed-back
// value equals a captured limit, and pulses done. In auto-reload mode the
// load/run cycle repeats until abort. pcnt counts completed periods since the
// last accepted start and saturates at all-ones.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous reset, active-low
//   bus    : cntr_seq_if.slave
//            in  start, abort, auto_reload, start_val, limit, cnt_val
//            out cnt_in, load, enab, busy, done, pcnt
// ---------------------------------------------------------------------------
module cntr_seq #(
    parameter int WIDTH  = 5,
    parameter int PCNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    cntr_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_start_val;
    logic [WIDTH-1:0]  r_limit;
    logic              r_auto;
    logic              r_done;
    logic [PCNT_W-1:0] r_pcnt;

    logic              w_match;

    function automatic logic [PCNT_W-1:0] sat_inc(input logic [PCNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // Match is only meaningful while the counter is running; in other states
    // cnt_val is stale or being reloaded.
    assign w_match = (r_state == S_RUN) && (bus.cnt_val == r_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_start_val <= '0;
            r_limit     <= '0;
            r_auto      <= 1'b0;
            r_done      <= 1'b0;
            r_pcnt      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_start_val <= bus.start_val;
                        r_limit     <= bus.limit;
                        r_auto      <= bus.auto_reload;
                        r_pcnt      <= '0;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= bus.abort ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    // Abort wins over a coincident match: the period is
                    // discarded without done or a pcnt update.
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else if (w_match) begin
                        r_done  <= 1'b1;
                        r_pcnt  <= sat_inc(r_pcnt);
                        r_state <= r_auto ? S_LOAD : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // load/enab are decoded from state so the counter stops exactly on the
    // limit instead of overshooting by one.
    assign bus.load   = (r_state == S_LOAD);
    assign bus.enab   = (r_state == S_RUN) && !w_match;
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.cnt_in = r_start_val;
    assign bus.done   = r_done;
    assign bus.pcnt   = r_pcnt;

endmodule

// File: tb/tb_cntr_seq.sv
// ---------------------------------------------------------------------------
// tb_cntr_seq
// Drives cntr_seq with a loadable up-counter model in the feedback path and
// compares every cycle against a phase-based reference of the sequence
// timeline (load phase, N enable phases, one match phase).
// ---------------------------------------------------------------------------
module tb_cntr_seq;
    localparam int W  = 5;
    localparam int PW = 8;
    localparam int MODV = 1 << W;
    localparam int PMAX = (1 << PW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cntr_seq_if #(.WIDTH(W), .PCNT_W(PW)) bus ();

    cntr_seq #(.WIDTH(W), .PCNT_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Loadable up-counter on the other side of the sequencer.
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_cnt <= '0;
        else if (bus.load) r_cnt <= bus.cnt_in;
        else if (bus.enab) r_cnt <= r_cnt + 1'b1;
    end
    assign bus.cnt_val = r_cnt;

    // Reference: position within the current period.
    // phase 0 = load, phases 1..N = enable, phase N+1 = match.
    int m_active, m_phase, m_n, m_auto, m_sv, m_pcnt, m_done;
    int n_assert, n_fail;

    task automatic model_reset();
        m_active = 0; m_phase = 0; m_n = 0; m_auto = 0;
        m_sv = 0; m_pcnt = 0; m_done = 0;
    endtask

    task automatic model_step(input logic st, input logic ab, input logic ar,
                              input logic [W-1:0] sv, input logic [W-1:0] lim);
        m_done = 0;
        if (m_active == 0) begin
            if (st && !ab) begin
                m_active = 1;
                m_phase  = 0;
                m_sv     = int'(sv);
                m_n      = (int'(lim) - int'(sv) + MODV) % MODV;
                m_auto   = int'(ar);
                m_pcnt   = 0;
            end
        end else if (ab) begin
            m_active = 0;
        end else if (m_phase == m_n + 1) begin
            m_done = 1;
            if (m_pcnt < PMAX) m_pcnt = m_pcnt + 1;
            if (m_auto != 0) m_phase = 0;
            else             m_active = 0;
        end else begin
            m_phase = m_phase + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("load",   32'(bus.load),   32'(m_active != 0 && m_phase == 0));
        chk("enab",   32'(bus.enab),   32'(m_active != 0 && m_phase >= 1 && m_phase <= m_n));
        chk("busy",   32'(bus.busy),   32'(m_active != 0));
        chk("done",   32'(bus.done),   32'(m_done));
        chk("pcnt",   32'(bus.pcnt),   32'(m_pcnt));
        chk("cnt_in", 32'(bus.cnt_in), 32'(m_sv));
    endtask

    task automatic cyc(input logic st, input logic ab, input logic ar,
                       input logic [W-1:0] sv, input logic [W-1:0] lim);
        bus.start       = st;
        bus.abort       = ab;
        bus.auto_reload = ar;
        bus.start_val   = sv;
        bus.limit       = lim;
        @(posedge clk);
        if (rst_n) model_step(st, ab, ar, sv, lim);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        model_reset();
        bus.start = 1'b0; bus.abort = 1'b0; bus.auto_reload = 1'b0;
        bus.start_val = '0; bus.limit = '0;

        // Reset state
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // One-shot 3 -> 7
        cyc(1'b1, 1'b0, 1'b0, 5'd3, 5'd7);
        idle(8);
        chk("oneshot_stop", 32'(r_cnt), 32'd7);

        // Wrap 30 -> 2
        cyc(1'b1, 1'b0, 1'b0, 5'd30, 5'd2);
        idle(8);
        chk("wrap_stop", 32'(r_cnt), 32'd2);

        // Equal start and limit
        cyc(1'b1, 1'b0, 1'b0, 5'd9, 5'd9);
        idle(5);
        chk("equal_stop", 32'(r_cnt), 32'd9);

        // Auto-reload 0 -> 3, three periods, then abort mid-run
        cyc(1'b1, 1'b0, 1'b1, 5'd0, 5'd3);
        idle(15);
        chk("auto_pcnt3", 32'(bus.pcnt), 32'd3);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
        idle(8);

        // Abort coinciding with a match (auto mode, one period already done)
        cyc(1'b1, 1'b0, 1'b1, 5'd4, 5'd6);
        idle(7);
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
        idle(4);

        // Start while busy is ignored
        cyc(1'b1, 1'b0, 1'b0, 5'd10, 5'd20);
        idle(3);
        cyc(1'b1, 1'b0, 1'b1, 5'd0, 5'd1);
        idle(12);

        // Start together with abort in IDLE
        cyc(1'b1, 1'b1, 1'b0, 5'd5, 5'd6);
        idle(3);

        // pcnt saturation with two-cycle periods
        cyc(1'b1, 1'b0, 1'b1, 5'd11, 5'd11);
        idle(520);
        chk("pcnt_sat", 32'(bus.pcnt), 32'(PMAX));
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
        idle(2);

        // Asynchronous reset mid-run
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd20);
        idle(5);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_cnt", 32'(r_cnt), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, 5'd2, 5'd5);
        idle(6);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(logic'($urandom_range(0, 3) == 0),
                logic'($urandom_range(0, 24) == 0),
                logic'($urandom_range(0, 1)),
                W'($urandom_range(0, MODV - 1)),
                W'($urandom_range(0, MODV - 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
